// File: rtl/types.sv
// Shared bus and OAM DMA type definitions.
package types_pkg;

  // Memory bus request operation.
  typedef enum logic [1:0] {
    BUS_OP_IDLE  = 2'd0,
    BUS_OP_READ  = 2'd1,
    BUS_OP_WRITE = 2'd2
  } bus_op_t;

  // Memory bus transfer size.
  typedef enum logic {
    BUS_SIZE_BYTE = 1'b0,
    BUS_SIZE_WORD = 1'b1
  } bus_size_t;

  // OAM location and copy length.
  localparam logic [15:0] OAM_BASE_ADDR = 16'hFE00;
  localparam logic [7:0]  OAM_DMA_LEN   = 8'd160;

  // OAM DMA sequencer states.
  typedef enum logic [2:0] {
    DMA_IDLE    = 3'd0,
    DMA_RD_REQ  = 3'd1,
    DMA_RD_WAIT = 3'd2,
    DMA_WR_REQ  = 3'd3,
    DMA_WR_WAIT = 3'd4
  } oam_dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA bus initiator: copies OAM_DMA_LEN bytes from {start_page, 8'h00}
// to OAM_BASE_ADDR using one outstanding read/write transaction at a time.
// Optional macro OAM_DMA_WORD_EN switches to 16-bit word transfers.
module oam_dma
  import types_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  start_page,
  output logic        busy,
  output logic        done,
  output bus_op_t     req_op,
  output bus_size_t   req_size,
  output logic [15:0] req_addr,
  output logic [15:0] req_write_data,
  input  logic        resp_done,
  input  logic [15:0] resp_read_data
);

`ifdef OAM_DMA_WORD_EN
  localparam logic [7:0]  IDX_STEP  = 8'd2;
  localparam bus_size_t   XFER_SIZE = BUS_SIZE_WORD;
  localparam logic [15:0] DATA_MASK = 16'hFFFF;
`else
  localparam logic [7:0]  IDX_STEP  = 8'd1;
  localparam bus_size_t   XFER_SIZE = BUS_SIZE_BYTE;
  localparam logic [15:0] DATA_MASK = 16'h00FF;
`endif
  localparam logic [7:0] LAST_IDX = OAM_DMA_LEN - IDX_STEP;

  oam_dma_state_t state_r, state_s;
  logic [7:0]     idx_r, idx_s;
  logic [7:0]     page_r, page_s;
  logic [15:0]    data_r, data_s;
  logic           restart_r, restart_s;
  logic           busy_s, done_s;
  bus_op_t        req_op_s;
  logic [15:0]    req_addr_s, req_write_data_s;

  // Next-state, next-counter and next-output computation.
  always_comb begin
    state_s          = state_r;
    idx_s            = idx_r;
    page_s           = page_r;
    data_s           = data_r;
    restart_s        = restart_r;
    done_s           = 1'b0;
    req_op_s         = BUS_OP_IDLE;
    req_addr_s       = req_addr;
    req_write_data_s = req_write_data;

    // A start while busy latches the new page; the restart is taken when the
    // outstanding transaction completes.
    if (start && (state_r != DMA_IDLE)) begin
      page_s    = start_page;
      restart_s = 1'b1;
    end else begin
      restart_s = restart_r;
    end

    case (state_r)
      DMA_IDLE: begin
        if (start) begin
          page_s    = start_page;
          idx_s     = 8'd0;
          restart_s = 1'b0;
          state_s   = DMA_RD_REQ;
        end else begin
          state_s = DMA_IDLE;
        end
      end
      DMA_RD_REQ: state_s = DMA_RD_WAIT;
      DMA_RD_WAIT: begin
        if (resp_done) begin
          if (restart_s) begin
            idx_s     = 8'd0;
            restart_s = 1'b0;
            state_s   = DMA_RD_REQ;
          end else begin
            data_s  = resp_read_data & DATA_MASK;
            state_s = DMA_WR_REQ;
          end
        end else begin
          state_s = DMA_RD_WAIT;
        end
      end
      DMA_WR_REQ: state_s = DMA_WR_WAIT;
      DMA_WR_WAIT: begin
        if (resp_done) begin
          if (restart_s) begin
            idx_s     = 8'd0;
            restart_s = 1'b0;
            state_s   = DMA_RD_REQ;
          end else if (idx_r == LAST_IDX) begin
            done_s  = 1'b1;
            state_s = DMA_IDLE;
          end else begin
            idx_s   = idx_r + IDX_STEP;
            state_s = DMA_RD_REQ;
          end
        end else begin
          state_s = DMA_WR_WAIT;
        end
      end
      default: begin
        state_s   = DMA_IDLE;
        restart_s = 1'b0;
      end
    endcase

    busy_s = (state_s != DMA_IDLE);

    case (state_s)
      DMA_RD_REQ: begin
        req_op_s   = BUS_OP_READ;
        req_addr_s = {page_s, idx_s};
      end
      DMA_WR_REQ: begin
        req_op_s         = BUS_OP_WRITE;
        req_addr_s       = OAM_BASE_ADDR + {8'h00, idx_s};
        req_write_data_s = data_s;
      end
      default: req_op_s = BUS_OP_IDLE;
    endcase
  end

  // State, counter and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= DMA_IDLE;
      idx_r          <= 8'd0;
      page_r         <= 8'd0;
      data_r         <= 16'h0000;
      restart_r      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      req_op         <= BUS_OP_IDLE;
      req_size       <= BUS_SIZE_BYTE;
      req_addr       <= 16'h0000;
      req_write_data <= 16'h0000;
    end else begin
      state_r        <= state_s;
      idx_r          <= idx_s;
      page_r         <= page_s;
      data_r         <= data_s;
      restart_r      <= restart_s;
      busy           <= busy_s;
      done           <= done_s;
      req_op         <= req_op_s;
      req_size       <= XFER_SIZE;
      req_addr       <= req_addr_s;
      req_write_data <= req_write_data_s;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized self-checking bench for oam_dma with a latency-randomized
// responder and a transaction-list reference model.
module tb_oam_dma;
  import types_pkg::*;

`ifdef OAM_DMA_WORD_EN
  localparam int        STEP  = 2;
  localparam bus_size_t XSIZE = BUS_SIZE_WORD;
`else
  localparam int        STEP  = 1;
  localparam bus_size_t XSIZE = BUS_SIZE_BYTE;
`endif
  localparam int PAIRS = 160 / STEP;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] addr;
    logic        sz;
    logic [15:0] wd;
  } trans_t;

  logic        clk, reset, start, busy, done, resp_done;
  logic [7:0]  start_page;
  bus_op_t     req_op;
  bus_size_t   req_size;
  logic [15:0] req_addr, req_write_data, resp_read_data;

  oam_dma dut (
    .clk(clk), .reset(reset), .start(start), .start_page(start_page),
    .busy(busy), .done(done), .req_op(req_op), .req_size(req_size),
    .req_addr(req_addr), .req_write_data(req_write_data),
    .resp_done(resp_done), .resp_read_data(resp_read_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat_lo  = 2;
  int lat_hi  = 2;
  int done_cnt = 0;
  int done_cyc = 0;
  int b2b_err  = 0;
  int overlap_err = 0;
  trans_t obs_q[$];
  trans_t exp_q[$];
  logic [7:0] oam [160];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source memory contents: page C0 holds xx^5A, other pages are page-tagged.
  function automatic logic [7:0] mb(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ ((a[15:8] == 8'hC0) ? 8'h00 : a[15:8]);
  endfunction

  function automatic logic [15:0] rd_value(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    if (STEP == 2) return {mb(a1), mb(a)};
    else return {a[7:0] ^ 8'hA5, mb(a)};
  endfunction

  // Responder and bus monitor.
  initial begin
    logic        pend;
    int          cnt;
    logic [15:0] pend_addr;
    logic        pend_rd;
    logic        prev_active;
    trans_t      t;
    pend = 1'b0; cnt = 0; pend_addr = 16'h0000; pend_rd = 1'b0; prev_active = 1'b0;
    resp_done = 1'b0;
    resp_read_data = 16'h0000;
    forever begin
      @(negedge clk);
      resp_done = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          resp_done = 1'b1;
          resp_read_data = pend_rd ? rd_value(pend_addr) : 16'($urandom);
        end
      end
      if (req_op != BUS_OP_IDLE) begin
        if (prev_active) b2b_err++;
        if (pend) overlap_err++;
        t.op = req_op; t.addr = req_addr; t.sz = req_size; t.wd = req_write_data;
        obs_q.push_back(t);
        if (req_op == BUS_OP_WRITE && req_addr >= 16'hFE00 && req_addr < 16'hFEA0) begin
          oam[req_addr - 16'hFE00] = req_write_data[7:0];
          if (STEP == 2 && req_addr < 16'hFE9F) oam[req_addr - 16'hFDFF] = req_write_data[15:8];
        end
        pend = 1'b1;
        pend_addr = req_addr;
        pend_rd = (req_op == BUS_OP_READ);
        cnt = (lat_lo == lat_hi) ? lat_lo : int'($urandom_range(lat_hi, lat_lo));
        prev_active = 1'b1;
      end else begin
        prev_active = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic add_read(input logic [7:0] p, input int i);
    trans_t t;
    t.op = BUS_OP_READ; t.addr = {p, 8'(i)}; t.sz = XSIZE; t.wd = 16'h0000;
    exp_q.push_back(t);
  endtask

  task automatic add_pairs(input logic [7:0] p, input int npairs);
    trans_t t;
    logic [15:0] a;
    for (int k = 0; k < npairs; k++) begin
      a = {p, 8'(k * STEP)};
      add_read(p, k * STEP);
      t.op = BUS_OP_WRITE; t.addr = 16'hFE00 + 16'(k * STEP); t.sz = XSIZE;
      t.wd = (STEP == 2) ? rd_value(a) : {8'h00, mb(a)};
      exp_q.push_back(t);
    end
  endtask

  task automatic check_seq(input string tag);
    int errs;
    errs = 0;
    check({tag, "_ntrans"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i].op != exp_q[i].op || obs_q[i].addr != exp_q[i].addr ||
          obs_q[i].sz != exp_q[i].sz ||
          (exp_q[i].op == BUS_OP_WRITE && obs_q[i].wd != exp_q[i].wd)) errs++;
    end
    check({tag, "_seq_errs"}, errs, 0);
  endtask

  task automatic check_oam(input string tag, input logic [7:0] p);
    int errs;
    errs = 0;
    for (int i = 0; i < 160; i++)
      if (oam[i] !== mb({p, 8'(i)})) errs++;
    check({tag, "_oam_errs"}, errs, 0);
  endtask

  task automatic clear_models();
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 160; i++) oam[i] = 8'h00;
    done_cnt = 0; b2b_err = 0; overlap_err = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    clear_models();
  endtask

  task automatic kick(input logic [7:0] p, output int n);
    n = cyc;
    start = 1'b1; start_page = p;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k;
    k = 0;
    while (!done && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (!done) check({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int pos;
    reset = 1'b1; start = 1'b0; start_page = 8'h00;
    @(negedge clk);
    do_reset();

    // Reset state.
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_op", req_op, BUS_OP_IDLE);
    check("rst_size", req_size, BUS_SIZE_BYTE);
    check("rst_addr", req_addr, 16'h0000);
    check("rst_wdata", req_write_data, 16'h0000);

    // Fixed two-cycle responder, page C0.
    lat_lo = 2; lat_hi = 2;
    kick(8'hC0, n);
    check("t1_busy", busy, 1'b1);
    check("t1_first_op", req_op, BUS_OP_READ);
    check("t1_first_addr", req_addr, 16'hC000);
    wait_done("t1", 3000);
    check("t1_done_cycle", done_cyc, n + 6 * PAIRS + 1);
    check("t1_busy_at_done", busy, 1'b0);
    @(negedge clk);
    check("t1_done_single", done, 1'b0);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_b2b", b2b_err, 0);
    add_pairs(8'hC0, PAIRS);
    check_seq("t1");
    check_oam("t1", 8'hC0);

    // Random latency 1..8.
    do_reset();
    lat_lo = 1; lat_hi = 8;
    kick(8'hC0, n);
    wait_done("t2", 4000);
    @(negedge clk);
    add_pairs(8'hC0, PAIRS);
    check_seq("t2");
    check_oam("t2", 8'hC0);
    check("t2_overlap", overlap_err, 0);
    check("t2_b2b", b2b_err, 0);
    check("t2_done_cnt", done_cnt, 1);

    // Restart during RD_WAIT at idx 50.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    kick(8'hC0, n);
    pos = 0;
    while (!(req_op == BUS_OP_READ && req_addr == 16'hC032) && pos < 2000) begin
      @(negedge clk);
      pos++;
    end
    check("t3_found_idx50", (req_op == BUS_OP_READ && req_addr == 16'hC032), 1'b1);
    @(negedge clk);
    start = 1'b1; start_page = 8'h80;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3", 3000);
    @(negedge clk);
    add_pairs(8'hC0, 50 / STEP);
    add_read(8'hC0, 50);
    add_pairs(8'h80, PAIRS);
    check_seq("t3");
    check_oam("t3", 8'h80);
    check("t3_done_cnt", done_cnt, 1);

    // Reset during WR_WAIT with a late response.
    do_reset();
    lat_lo = 5; lat_hi = 5;
    kick(8'h40, n);
    pos = 0;
    while (req_op != BUS_OP_WRITE && pos < 100) begin
      @(negedge clk);
      pos++;
    end
    check("t4_found_write", req_op, BUS_OP_WRITE);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4_busy", busy, 1'b0);
    check("t4_op", req_op, BUS_OP_IDLE);
    check("t4_addr", req_addr, 16'h0000);
    n = obs_q.size();
    repeat (20) @(negedge clk);
    check("t4_no_late_req", obs_q.size(), n);
    check("t4_no_done", done_cnt, 0);

    // Top page: addresses verbatim, no wrap.
    do_reset();
    lat_lo = 1; lat_hi = 4;
    kick(8'hFF, n);
    wait_done("t5", 3000);
    @(negedge clk);
    add_pairs(8'hFF, PAIRS);
    check_seq("t5");
    check_oam("t5", 8'hFF);
    pos = -1;
    for (int i = 0; i < obs_q.size(); i++)
      if (obs_q[i].op == BUS_OP_READ) pos = i;
    check("t5_last_read", (pos >= 0) ? obs_q[pos].addr : 16'h0000, 16'hFF00 + 16'(160 - STEP));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
